iiitb_r2_8by4_div: RTL and testbench

Sequential radix-2 signed divider: 8-bit two's-complement dividend by 4-bit two's-complement divisor, giving an 8-bit quotient and a 4-bit remainder. It is the inverse operation of the team's 4×4 radix-2 Booth multiplier: that block's 8-bit product is a valid dividend here, and its multiplier operand is a valid divisor. The block sits in `user_proj_example` beside the multiplier and is driven from the same `mprj_io` input pads. Results go out on spare `io_out` bits, with status flags for divide-by-zero and overflow.

---
 rtl/iiitb_r2_8by4_div.sv | 146 ++++++++++++++
 tb/tb_iiitb_r2_8by4_div.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/iiitb_r2_8by4_div.sv
// Sequential radix-2 restoring signed divider: 8-bit dividend / 4-bit divisor.
// Magnitudes are divided over 8 cycles, then signs are applied with overflow saturation.
module iiitb_r2_8by4_div (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] N,
    input  logic [3:0] D,
    output logic [7:0] Q,
    output logic [3:0] R,
    output logic       busy,
    output logic       done,
    output logic       dbz,
    output logic       ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state, state_n;
    logic [7:0]  r_qr,   qr_n;
    logic [3:0]  r_pr,   pr_n;
    logic [3:0]  r_dmag, dmag_n;
    logic        r_sq,   sq_n;
    logic        r_sr,   sr_n;
    logic [3:0]  r_cnt,  cnt_n;
    logic [7:0]  r_q,    q_n;
    logic [3:0]  r_r,    r_n;
    logic        r_done, done_n;
    logic        r_dbz,  dbz_n;
    logic        r_ovf,  ovf_n;

    logic [7:0]  w_nmag;
    logic [3:0]  w_dmag;
    logic [4:0]  w_pr_sh;
    logic        w_ge;
    logic [3:0]  w_pr_sub;
    logic [7:0]  w_qfix;
    logic [3:0]  w_rfix;
    logic        w_ovf;

    assign w_nmag  = N[7] ? (8'd0 - N) : N;
    assign w_dmag  = D[3] ? (4'd0 - D) : D;
    assign w_pr_sh = {r_pr, r_qr[7]};
    assign w_ge    = (w_pr_sh >= {1'b0, r_dmag});
    // When w_ge holds the difference is below |D| <= 8, so the low 4 bits are exact.
    assign w_pr_sub = w_pr_sh[3:0] - r_dmag;
    assign w_qfix  = r_sq ? (8'd0 - r_qr) : r_qr;
    assign w_rfix  = r_sr ? (4'd0 - r_pr) : r_pr;
    assign w_ovf   = ~r_sq & r_qr[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_qr    <= 8'd0;
            r_pr    <= 4'd0;
            r_dmag  <= 4'd0;
            r_sq    <= 1'b0;
            r_sr    <= 1'b0;
            r_cnt   <= 4'd0;
            r_q     <= 8'd0;
            r_r     <= 4'd0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= state_n;
            r_qr    <= qr_n;
            r_pr    <= pr_n;
            r_dmag  <= dmag_n;
            r_sq    <= sq_n;
            r_sr    <= sr_n;
            r_cnt   <= cnt_n;
            r_q     <= q_n;
            r_r     <= r_n;
            r_done  <= done_n;
            r_dbz   <= dbz_n;
            r_ovf   <= ovf_n;
        end
    end

    always_comb begin
        state_n = r_state;
        qr_n    = r_qr;
        pr_n    = r_pr;
        dmag_n  = r_dmag;
        sq_n    = r_sq;
        sr_n    = r_sr;
        cnt_n   = r_cnt;
        q_n     = r_q;
        r_n     = r_r;
        done_n  = 1'b0;
        dbz_n   = r_dbz;
        ovf_n   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    if (D == 4'd0) begin
                        q_n    = 8'd0;
                        r_n    = 4'd0;
                        dbz_n  = 1'b1;
                        ovf_n  = 1'b0;
                        done_n = 1'b1;
                    end else begin
                        qr_n    = w_nmag;
                        dmag_n  = w_dmag;
                        sq_n    = N[7] ^ D[3];
                        sr_n    = N[7];
                        pr_n    = 4'd0;
                        cnt_n   = 4'd8;
                        state_n = S_CALC;
                    end
                end
            end
            S_CALC: begin
                pr_n = w_ge ? w_pr_sub : w_pr_sh[3:0];
                qr_n = {r_qr[6:0], w_ge};
                cnt_n = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    state_n = S_FIX;
                end
            end
            S_FIX: begin
                // Only -128 / -1 yields a positive magnitude of 128.
                q_n     = w_ovf ? 8'h7F : w_qfix;
                ovf_n   = w_ovf;
                r_n     = w_rfix;
                dbz_n   = 1'b0;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign Q    = r_q;
    assign R    = r_r;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign dbz  = r_dbz;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_iiitb_r2_8by4_div.sv
// Directed bench for iiitb_r2_8by4_div: hand-computed quotients, remainders,
// flags, latency, busy-load rejection and reset abort.
module tb_iiitb_r2_8by4_div;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] N;
    logic [3:0] D;
    logic [7:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       dbz;
    logic       ovf;

    int checks;
    int failures;
    int both_high;

    iiitb_r2_8by4_div dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .N     (N),
        .D     (D),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done && busy) both_high++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after an edge; counts further edges until done, bounded.
    task automatic wait_done(input int start, output int lat, output int bc);
        lat = start;
        bc  = 0;
        while (!done && lat < 30) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_div(input string tag, input logic [7:0] n, input logic [3:0] d,
                           input int exp_lat, input int exp_busy,
                           input logic [7:0] eq, input logic [3:0] er,
                           input logic edbz, input logic eovf);
        int lat;
        int bc;
        @(negedge clk);
        N = n;
        D = d;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        wait_done(0, lat, bc);
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " busy_cycles"}, bc, exp_busy);
        check_eq({tag, " Q"}, Q, eq);
        check_eq({tag, " R"}, R, er);
        check_eq({tag, " dbz"}, dbz, edbz);
        check_eq({tag, " ovf"}, ovf, eovf);
        @(posedge clk);
        #1;
        check_eq({tag, " done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        int bc;
        int dcount;
        checks    = 0;
        failures  = 0;
        both_high = 0;
        reset = 1'b1;
        load  = 1'b0;
        N     = 8'd0;
        D     = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst Q", Q, 8'h00);
        check_eq("rst R", R, 4'h0);
        check_eq("rst busy", busy, 1'b0);
        check_eq("rst done", done, 1'b0);
        check_eq("rst dbz", dbz, 1'b0);
        check_eq("rst ovf", ovf, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        run_div("100/7",     8'h64, 4'h7, 9, 9, 8'h0E, 4'h2, 1'b0, 1'b0);
        run_div("-100/7",    8'h9C, 4'h7, 9, 9, 8'hF2, 4'hE, 1'b0, 1'b0);
        run_div("127/-8",    8'h7F, 4'h8, 9, 9, 8'hF1, 4'h7, 1'b0, 1'b0);
        run_div("-128/1",    8'h80, 4'h1, 9, 9, 8'h80, 4'h0, 1'b0, 1'b0);
        run_div("-128/-1",   8'h80, 4'hF, 9, 9, 8'h7F, 4'h0, 1'b0, 1'b1);
        run_div("37/0",      8'h25, 4'h0, 0, 0, 8'h00, 4'h0, 1'b1, 1'b0);
        run_div("-30/6",     8'hE2, 4'h6, 9, 9, 8'hFB, 4'h0, 1'b0, 1'b0);
        run_div("-7/3",      8'hF9, 4'h3, 9, 9, 8'hFE, 4'hF, 1'b0, 1'b0);

        // load during CALC must be ignored
        @(negedge clk);
        N = 8'h64;
        D = 4'h7;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        N = 8'h80;
        D = 4'hF;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        wait_done(3, lat, bc);
        check_eq("busyload latency", lat, 9);
        check_eq("busyload Q", Q, 8'h0E);
        check_eq("busyload R", R, 4'h2);
        check_eq("busyload ovf", ovf, 1'b0);

        // reset abort mid-CALC
        @(negedge clk);
        N = 8'h64;
        D = 4'h7;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort Q", Q, 8'h00);
        check_eq("abort R", R, 4'h0);
        check_eq("abort busy", busy, 1'b0);
        check_eq("abort done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check_eq("abort no_done", dcount, 0);
        check_eq("abort idle", busy, 1'b0);

        run_div("post-reset 127/-8", 8'h7F, 4'h8, 9, 9, 8'hF1, 4'h7, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check_eq("hold Q", Q, 8'hF1);
        check_eq("hold R", R, 4'h7);
        check_eq("done_busy_exclusive", both_high, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
